// File: rtl/div_ratio_detect_if.sv
// Signal bundle between a divided-clock source and the ratio detector.
// The source drives din; the detector returns its measurement results.
interface div_ratio_detect_if #(
  parameter int unsigned MAX_PERIOD = 16
);
  localparam int unsigned CW = $clog2(MAX_PERIOD + 1);

  logic          din;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          valid;
  logic          locked;
  logic          duty50;
  logic          mismatch;
  logic          timeout;

  modport master (
    output din,
    input  period, high_time, valid, locked, duty50, mismatch, timeout
  );

  modport slave (
    input  din,
    output period, high_time, valid, locked, duty50, mismatch, timeout
  );
endinterface

// File: rtl/div_ratio_detect.sv
// Measures the rising-edge period and high time of a divided waveform,
// and reports lock, 50% duty, mismatch and missing-edge timeout.
module div_ratio_detect #(
  parameter int unsigned MAX_PERIOD = 16,
  parameter int unsigned LOCK_COUNT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  div_ratio_detect_if.slave     bus
);
  localparam int unsigned   CW      = $clog2(MAX_PERIOD + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PERIOD);
  localparam logic [2:0]    LOCK_M  = 3'(LOCK_COUNT);

  typedef enum logic {IDLE, MEASURE} state_e;

  state_e        state_q, state_d;
  logic          din_q, din_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [2:0]    match_q, match_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] high_q, high_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;
  logic          mismatch_q, mismatch_d;
  logic          timeout_q, timeout_d;
  logic          rise;

  assign rise = bus.din & ~din_q;

  // Next-state and measurement bookkeeping
  always_comb begin
    state_d    = state_q;
    din_d      = bus.din;
    cnt_d      = cnt_q;
    hcnt_d     = hcnt_q;
    match_d    = match_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    mismatch_d = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = CW'(1);
          hcnt_d  = CW'(1);
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          cnt_d    = CW'(1);
          hcnt_d   = CW'(1);
          // match_q == 0 only right after IDLE: first measurement has no reference
          if (match_q == 3'd0) begin
            match_d = 3'd1;
          end else if (cnt_q == period_q && hcnt_q == high_q) begin
            match_d = (match_q >= LOCK_M) ? LOCK_M : match_q + 3'd1;
          end else begin
            match_d    = 3'd1;
            mismatch_d = locked_q;
          end
        end else if (cnt_q == MAX_CNT) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          match_d   = 3'd0;
          cnt_d     = '0;
          hcnt_d    = '0;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          hcnt_d = hcnt_q + CW'(bus.din);
        end
      end
    endcase

    locked_d = (match_d >= LOCK_M);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      din_q      <= 1'b0;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      match_q    <= 3'd0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      din_q      <= din_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      match_q    <= match_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      mismatch_q <= mismatch_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_q;
  assign bus.valid     = valid_q;
  assign bus.locked    = locked_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.timeout   = timeout_q;
  assign bus.duty50    = locked_q && ({high_q, 1'b0} == {1'b0, period_q});
endmodule

// File: tb/tb_div_ratio_detect.sv
// Bench for div_ratio_detect: directed divider patterns plus random
// waveforms compared against an edge-history reference model.
module tb_div_ratio_detect;
  localparam int unsigned MAXP  = 16;
  localparam int unsigned LOCKN = 3;
  localparam int unsigned CW    = $clog2(MAXP + 1);
  localparam int unsigned OW    = 2 * CW + 5;

  logic clk = 1'b0;
  logic reset;

  div_ratio_detect_if #(.MAX_PERIOD(MAXP)) bus ();

  div_ratio_detect #(.MAX_PERIOD(MAXP), .LOCK_COUNT(LOCKN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: full din history, index of the reference rise
  bit hist[$];
  bit m_have = 1'b0;
  bit m_prev = 1'b0;
  int m_last = 0;
  int m_matches = 0;
  int m_p = 0;
  int m_h = 0;
  bit m_valid = 1'b0;
  bit m_mis = 1'b0;
  bit m_to = 1'b0;

  function automatic logic [OW-1:0] obs();
    return {bus.period, bus.high_time, bus.valid, bus.locked, bus.duty50,
            bus.mismatch, bus.timeout};
  endfunction

  function automatic logic [OW-1:0] expv();
    bit lock;
    bit duty;
    lock = (m_matches >= LOCKN);
    duty = lock && (2 * m_h == m_p);
    return {CW'(m_p), CW'(m_h), m_valid, lock, duty, m_mis, m_to};
  endfunction

  // One clock: drive inputs, advance the model on the edge, settle past it
  task automatic step(input logic d, input logic r);
    int n;
    int p;
    int h;
    bit rise;
    bus.din = d;
    reset   = r;
    @(posedge clk);
    n = hist.size();
    m_valid = 1'b0;
    m_mis   = 1'b0;
    m_to    = 1'b0;
    if (r) begin
      m_have = 1'b0; m_prev = 1'b0; m_matches = 0; m_p = 0; m_h = 0;
    end else begin
      rise   = d && !m_prev;
      m_prev = d;
      if (!m_have) begin
        if (rise) begin m_have = 1'b1; m_last = n; end
      end else if (rise) begin
        p = n - m_last;
        h = 0;
        for (int i = m_last; i < n; i++) h += int'(hist[i]);
        m_valid = 1'b1;
        if (m_matches == 0) m_matches = 1;
        else if (p == m_p && h == m_h) m_matches = (m_matches >= LOCKN) ? LOCKN : m_matches + 1;
        else begin
          m_mis = (m_matches >= LOCKN);
          m_matches = 1;
        end
        m_p = p; m_h = h; m_last = n;
      end else if (n - m_last == MAXP) begin
        m_to = 1'b1; m_have = 1'b0; m_matches = 0;
      end
    end
    hist.push_back(d);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    checks++;
    if (obs() !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", obs());
    end
    step(1'b0, 1'b0);
    checks++;
    if (obs() !== expv()) begin
      fails++;
      $display("FAIL reset_idle: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_periodic(input string name, input logic [15:0] pat, input int len,
                               input int reps, input int ep, input int eh);
    int vcount;
    logic [15:0] pv;
    pv = pat;
    vcount = 0;
    step(1'b0, 1'b1);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < len; i++) begin
        step(pv[i], 1'b0);
        checks++;
        if (obs() !== expv()) begin
          fails++;
          $display("FAIL %s model r=%0d i=%0d: got %h expected %h", name, r, i, obs(), expv());
        end
        if (bus.valid === 1'b1) begin
          vcount++;
          checks++;
          if (bus.period !== CW'(ep) || bus.high_time !== CW'(eh) ||
              bus.locked !== (vcount >= 3) || bus.duty50 !== ((vcount >= 3) && (2 * eh == ep))) begin
            fails++;
            $display("FAIL %s valid#%0d: got p=%0d h=%0d lock=%b d50=%b expected p=%0d h=%0d lock=%b",
                     name, vcount, bus.period, bus.high_time, bus.locked, bus.duty50, ep, eh, vcount >= 3);
          end
        end
      end
    end
    checks++;
    if (vcount < 3) begin
      fails++;
      $display("FAIL %s valid_count: got %0d expected >=3", name, vcount);
    end
  endtask

  task automatic test_mismatch();
    logic [17:0] seq;
    seq = 18'b10_000010_001110;
    step(1'b0, 1'b1);
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 6; i++) step(seq[i], 1'b0);
    for (int i = 0; i < 6; i++) step(seq[6 + i], 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (bus.valid !== 1'b1 || bus.period !== CW'(6) || bus.high_time !== CW'(1) ||
        bus.mismatch !== 1'b1 || bus.locked !== 1'b0 || bus.duty50 !== 1'b0) begin
      fails++;
      $display("FAIL mismatch: got v=%b p=%0d h=%0d mis=%b lock=%b d50=%b expected v=1 p=6 h=1 mis=1 lock=0 d50=0",
               bus.valid, bus.period, bus.high_time, bus.mismatch, bus.locked, bus.duty50);
    end
    checks++;
    if (obs() !== expv()) begin
      fails++;
      $display("FAIL mismatch_model: got %h expected %h", obs(), expv());
    end
    step(1'b0, 1'b0);
    checks++;
    if (bus.mismatch !== 1'b0) begin
      fails++;
      $display("FAIL mismatch_pulse_width: got %b expected 0", bus.mismatch);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] pat;
    int rise_idx;
    int seen;
    int vseen;
    pat = 4'b0110;
    seen = 0;
    vseen = 0;
    step(1'b0, 1'b1);
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 4; i++) step(pat[i], 1'b0);
    checks++;
    if (bus.locked !== 1'b1) begin
      fails++;
      $display("FAIL timeout_prelock: got %b expected 1", bus.locked);
    end
    rise_idx = hist.size() - 3;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0);
      checks++;
      if (obs() !== expv()) begin
        fails++;
        $display("FAIL timeout_model k=%0d: got %h expected %h", k, obs(), expv());
      end
      if (bus.timeout === 1'b1) begin
        seen++;
        checks++;
        if ((hist.size() - 1 - rise_idx) != 16 || bus.locked !== 1'b0 || bus.period !== CW'(4)) begin
          fails++;
          $display("FAIL timeout_pulse: got dist=%0d lock=%b p=%0d expected dist=16 lock=0 p=4",
                   hist.size() - 1 - rise_idx, bus.locked, bus.period);
        end
      end
    end
    checks++;
    if (seen != 1) begin
      fails++;
      $display("FAIL timeout_count: got %0d expected 1", seen);
    end
    step(1'b1, 1'b0); if (bus.valid === 1'b1) vseen++;
    step(1'b1, 1'b0); if (bus.valid === 1'b1) vseen++;
    step(1'b0, 1'b0); if (bus.valid === 1'b1) vseen++;
    checks++;
    if (vseen != 0) begin
      fails++;
      $display("FAIL timeout_no_valid: got %0d valids expected 0", vseen);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] pat;
    logic [4:0] post;
    int early;
    pat = 4'b0110;
    post = 5'b10011;
    early = 0;
    step(1'b0, 1'b1);
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 4; i++) step(pat[i], 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++;
    if (obs() !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %h expected 0", obs());
    end
    for (int i = 0; i < 4; i++) begin
      step(post[i], 1'b0);
      if (bus.valid === 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      fails++;
      $display("FAIL reset_mid_early_valid: got %0d expected 0", early);
    end
    step(post[4], 1'b0);
    checks++;
    if (bus.valid !== 1'b1 || bus.period !== CW'(4) || bus.high_time !== CW'(2)) begin
      fails++;
      $display("FAIL reset_mid_restart: got v=%b p=%0d h=%0d expected v=1 p=4 h=2",
               bus.valid, bus.period, bus.high_time);
    end
  endtask

  task automatic test_max_period();
    int v16;
    int tos;
    v16 = 0;
    tos = 0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < MAXP + ((r == 4) ? 2 : 0); i++) begin
        step((i == 0), 1'b0);
        checks++;
        if (obs() !== expv()) begin
          fails++;
          $display("FAIL max_period_model r=%0d i=%0d: got %h expected %h", r, i, obs(), expv());
        end
        if (bus.valid === 1'b1 && bus.period === CW'(MAXP)) v16++;
        if (bus.timeout === 1'b1) tos++;
      end
    end
    checks++;
    if (v16 != 4 || tos != 1) begin
      fails++;
      $display("FAIL max_period: got %0d p16 valids %0d timeouts expected 4 and 1", v16, tos);
    end
  endtask

  task automatic test_random();
    int kind;
    int p;
    int h;
    int reps;
    int len;
    bit lvl;
    step(1'b0, 1'b1);
    for (int s = 0; s < 80; s++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        step(1'($urandom_range(0, 1)), 1'b1);
        checks++;
        if (obs() !== expv()) begin
          fails++;
          $display("FAIL random_reset s=%0d: got %h expected %h", s, obs(), expv());
        end
      end else if (kind <= 2) begin
        len = (kind == 1) ? int'($urandom_range(1, 20)) : int'($urandom_range(15, 20));
        lvl = 1'($urandom_range(0, 1));
        for (int i = 0; i < len; i++) begin
          step((kind == 1) ? 1'($urandom_range(0, 1)) : lvl, 1'b0);
          checks++;
          if (obs() !== expv()) begin
            fails++;
            $display("FAIL random_noise s=%0d i=%0d: got %h expected %h", s, i, obs(), expv());
          end
        end
      end else begin
        p = int'($urandom_range(2, MAXP + 2));
        h = int'($urandom_range(1, p - 1));
        reps = int'($urandom_range(1, 5));
        for (int r = 0; r < reps; r++) begin
          for (int i = 0; i < p; i++) begin
            step((i < h), 1'b0);
            checks++;
            if (obs() !== expv()) begin
              fails++;
              $display("FAIL random_periodic s=%0d p=%0d h=%0d: got %h expected %h",
                       s, p, h, obs(), expv());
            end
          end
        end
      end
    end
  endtask

  initial begin
    bus.din = 1'b0;
    reset   = 1'b1;
    test_reset();
    test_periodic("div2", 16'b10, 2, 8, 2, 1);
    test_periodic("div4", 16'b0110, 4, 6, 4, 2);
    test_periodic("div6", 16'b001110, 6, 5, 6, 3);
    test_periodic("div5", 16'b00110, 5, 5, 5, 2);
    test_mismatch();
    test_timeout();
    test_reset_mid();
    test_max_period();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/div_ratio_detect.md
DIV_RATIO_DETECT -- requirements
Module: div_ratio_detect

Interface
REQ-001 SHALL have parameter MAX_PERIOD, default 16, meaning the longest measurable din period in clk cycles (range 2..255).
REQ-002 SHALL have parameter LOCK_COUNT, default 3, meaning the number of consecutive identical measurements needed to assert locked (range 2..7).
REQ-003 SHALL use CW = clog2(MAX_PERIOD+1) as the counter and output width (5 at the defaults).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port din, input, 1 bit: the divided waveform, synchronous to clk.
REQ-007 SHALL have port period, output, CW bits: the last measured rising-edge-to-rising-edge distance, in clk cycles.
REQ-008 SHALL have port high_time, output, CW bits: the number of din=1 cycles in that period.
REQ-009 SHALL have port valid, output, 1 bit: a one-cycle pulse for each new measurement.
REQ-010 SHALL have port locked, output, 1 bit: the measurements are stable.
REQ-011 SHALL have port duty50, output, 1 bit: locked and 2*high_time == period.
REQ-012 SHALL have port mismatch, output, 1 bit: a one-cycle pulse when a locked measurement changes.
REQ-013 SHALL have port timeout, output, 1 bit: a one-cycle pulse when no rising edge arrives within MAX_PERIOD cycles.

Function
REQ-014 SHALL register din into din_q every cycle.
REQ-015 SHALL define a rising edge ("rise") as din=1 and din_q=0 sampled on the same clk edge.
REQ-016 SHALL implement an FSM with two states: IDLE (no reference edge) and MEASURE.
REQ-017 In IDLE, on rise, SHALL go to MEASURE, set cnt=1 and hcnt=1, and not pulse valid.
REQ-018 In MEASURE with no rise, SHALL increment cnt and increment hcnt when din=1.
REQ-019 In MEASURE on rise, SHALL load period<=cnt and high_time<=hcnt, pulse valid, then set cnt=1 and hcnt=1.
REQ-020 Latency: period, high_time and valid SHALL be registered, becoming visible in the cycle after the rise is sampled.
REQ-021 On rise with cnt == MAX_PERIOD, SHALL accept the measurement normally (period = MAX_PERIOD).
REQ-022 In MEASURE, when cnt == MAX_PERIOD and there is no rise, SHALL:
- go to IDLE;
- pulse timeout;
- clear locked and match_cnt;
- hold period and high_time unchanged.
REQ-023 SHALL treat din held constant (0 or 1) in MEASURE as a timeout per REQ-022.
REQ-024 SHALL track match_cnt, a 3-bit count saturating at LOCK_COUNT.
REQ-025 On the first measurement after IDLE, SHALL set match_cnt=1.
REQ-026 On a later measurement equal in both period and high_time to the previous one, SHALL increment match_cnt.
REQ-027 On a later measurement that differs, SHALL set match_cnt=1.
REQ-028 SHALL drive locked = (match_cnt >= LOCK_COUNT), registered with match_cnt.
REQ-029 When locked=1 and a differing measurement arrives, SHALL:
- pulse mismatch in the same cycle valid pulses;
- drive locked=0 that cycle.
REQ-030 SHALL drive duty50 combinationally from the registered locked, period and high_time.
REQ-031 SHALL not let valid, mismatch and timeout all be 1 together; valid and timeout SHALL be mutually exclusive.

Reset
REQ-032 While reset=1 on a clk edge, SHALL set all of the following to 0:
- state=IDLE, din_q, cnt, hcnt, match_cnt;
- period, high_time;
- valid, locked, mismatch, timeout.
REQ-033 Reset SHALL override all other activity, including mid-measurement and a coincident rise.
REQ-034 If din=1 on the first cycle after reset deasserts, SHALL treat that cycle as a rise (din_q=0).

Verification
REQ-035 din repeating 0,1 (div2): valid every 2 cycles, period=2, high_time=1; locked=1 with the 3rd valid; duty50=1.
REQ-036 din repeating 0,1,1,0 (div4): period=4, high_time=2, locked after 3 measurements, duty50=1.
REQ-037 din repeating 0,1,1,1,0,0 (div6): period=6, high_time=3, duty50=1.
REQ-038 din repeating 0,1,1,1,0,0 then 0,1,0,0,0,0: first differing measurement gives period=6, high_time=1, mismatch=1, locked=0, duty50=0.
REQ-039 Locked at period 4, then din held 0:
- timeout pulses 16 cycles after the last rise;
- locked=0, period stays 4;
- the next rise gives no valid.
REQ-040 reset=1 for one cycle mid-period while locked:
- all outputs are 0 the next cycle;
- if din=1 on the first post-reset cycle, measurement restarts with valid at the following rise.
